// File: rtl/speck_job_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : speck_job_scheduler_pkg
// Desc   : Shared widths, timeout default and scheduler state encodings.
// Rev    : 1.0 - initial release
// ============================================================================
package speck_job_scheduler_pkg;

  localparam int c_DATA_W      = 128;
  localparam int c_N_REQ       = 2;
  localparam int c_TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESPOND = 3'd4
  } sched_state_t;

  // Counter width for a cycle budget; never narrower than one bit.
  function automatic int cnt_width(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/speck_job_scheduler_rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter_2
// Desc   : Two-way round-robin arbiter; ptr names the preferred requester.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2
  import speck_job_scheduler_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (req[ptr]) begin
      grant[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      grant[~ptr] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/speck_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module : speck_job_scheduler
// Desc   : Shares one SPECK core between two requesters with round-robin grant.
// Rev    : 1.0 - initial release
// ============================================================================
module speck_job_scheduler
  import speck_job_scheduler_pkg::*;
#(
  parameter int DATA_W      = c_DATA_W,
  parameter int N_REQ       = c_N_REQ,
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_decrypt,
  input  logic [N_REQ*DATA_W-1:0] req_text,
  input  logic [N_REQ*DATA_W-1:0] req_key,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_error,
  input  logic                    secret_storage_ready,
  output logic                    core_start,
  output logic                    core_decrypt,
  output logic [DATA_W-1:0]       core_text,
  output logic [DATA_W-1:0]       core_key,
  input  logic                    core_ready,
  input  logic [DATA_W-1:0]       core_result,
  output logic                    busy
);

  localparam int                 c_CNT_W    = cnt_width(TIMEOUT_CYC);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

  sched_state_t        r_state;
  sched_state_t        w_state_nxt;

  logic [DATA_W-1:0]   w_text [N_REQ];
  logic [DATA_W-1:0]   w_key  [N_REQ];
  logic [N_REQ-1:0]    w_grant;
  logic                w_gidx;
  logic                w_timeout;

  logic                r_rr_ptr;
  logic                r_grant_idx;
  logic [c_CNT_W-1:0]  r_timer;
  logic                r_core_decrypt;
  logic [DATA_W-1:0]   r_core_text;
  logic [DATA_W-1:0]   r_core_key;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_error;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_text[gi] = req_text[gi*DATA_W +: DATA_W];
      assign w_key[gi]  = req_key[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter_2 u_arb (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_grant)
  );

  assign w_gidx    = w_grant[1];
  assign w_timeout = (r_timer == c_CNT_LAST);

  assign core_decrypt = r_core_decrypt;
  assign core_text    = r_core_text;
  assign core_key     = r_core_key;
  assign rsp_data     = r_rsp_data;
  assign rsp_error    = r_rsp_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    core_start  = 1'b0;
    busy        = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if ((|req_valid) && secret_storage_ready) begin
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        req_ready = w_grant;
        // A requester that withdrew before the grant cycle leaves nothing to launch.
        w_state_nxt = (|w_grant) ? ST_LAUNCH : ST_IDLE;
      end
      ST_LAUNCH: begin
        core_start  = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_ready || w_timeout) begin
          w_state_nxt = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        rsp_valid[r_grant_idx] = 1'b1;
        if (rsp_ready[r_grant_idx]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr       <= 1'b0;
      r_grant_idx    <= 1'b0;
      r_timer        <= '0;
      r_core_decrypt <= 1'b0;
      r_core_text    <= '0;
      r_core_key     <= '0;
      r_rsp_data     <= '0;
      r_rsp_error    <= 1'b0;
    end else begin
      case (r_state)
        ST_GRANT: begin
          if (|w_grant) begin
            r_grant_idx    <= w_gidx;
            r_rr_ptr       <= ~w_gidx;
            r_core_text    <= w_text[w_gidx];
            r_core_key     <= w_key[w_gidx];
            r_core_decrypt <= req_decrypt[w_gidx];
          end
        end
        ST_LAUNCH: begin
          r_timer <= '0;
        end
        ST_WAIT: begin
          // core_ready takes priority over a timeout landing in the same cycle.
          if (core_ready) begin
            r_rsp_data  <= core_result;
            r_rsp_error <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_speck_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_speck_job_scheduler
// Desc   : Scoreboard bench for speck_job_scheduler with a SPECK128/128 core model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_speck_job_scheduler;
  import speck_job_scheduler_pkg::*;

  localparam logic [127:0] c_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] c_PT  = 128'h6c617669757165207469206564616d20;
  localparam logic [127:0] c_CT  = 128'ha65d9851797832657860fedf5c570d18;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid, req_ready, req_decrypt, rsp_valid, rsp_ready;
  logic [255:0] req_text, req_key;
  logic [127:0] rsp_data, core_text, core_key, core_result;
  logic         rsp_error, secret_storage_ready, core_start, core_decrypt;
  logic         core_ready, busy;

  always #5 clk = ~clk;

  speck_job_scheduler dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_decrypt          (req_decrypt),
    .req_text             (req_text),
    .req_key              (req_key),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .rsp_data             (rsp_data),
    .rsp_error            (rsp_error),
    .secret_storage_ready (secret_storage_ready),
    .core_start           (core_start),
    .core_decrypt         (core_decrypt),
    .core_text            (core_text),
    .core_key             (core_key),
    .core_ready           (core_ready),
    .core_result          (core_result),
    .busy                 (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference SPECK128/128 (32 rounds); text = {x,y}, key = {l0,k0}.
  function automatic logic [127:0] speck(input logic [127:0] t, input logic [127:0] k, input logic dec);
    logic [63:0] rk [32];
    logic [63:0] a, b, x, y;
    a = k[127:64];
    b = k[63:0];
    for (int i = 0; i < 32; i++) begin
      rk[i] = b;
      a = ({a[7:0], a[63:8]} + b) ^ 64'(i);
      b = {b[60:0], b[63:61]} ^ a;
    end
    x = t[127:64];
    y = t[63:0];
    if (!dec) begin
      for (int i = 0; i < 32; i++) begin
        x = ({x[7:0], x[63:8]} + y) ^ rk[i];
        y = {y[60:0], y[63:61]} ^ x;
      end
    end else begin
      for (int i = 31; i >= 0; i--) begin
        y = y ^ x;
        y = {y[2:0], y[63:3]};
        x = (x ^ rk[i]) - y;
        x = {x[55:0], x[63:56]};
      end
    end
    return {x, y};
  endfunction

  typedef struct {
    int           idx;
    logic [127:0] data;
    logic         err;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input int idx, input logic [127:0] data, input logic err);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  // Core model: responds core_lat cycles after core_start when enabled.
  bit           core_en   = 1'b1;
  int           core_lat  = 34;
  int           stray_cnt = 0;
  int           n_starts  = 0;

  initial begin
    bit           pend = 1'b0;
    int           cnt  = 0;
    int           stray_done = 0;
    logic [127:0] res = '0;
    core_ready  = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      #1;
      core_ready  = 1'b0;
      core_result = '0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            core_ready  = 1'b1;
            core_result = res;
            pend        = 1'b0;
          end
        end
        if (stray_cnt != stray_done) begin
          stray_done++;
          core_ready  = 1'b1;
          core_result = {4{32'hdeadbeef}};
        end
        if (core_start) begin
          n_starts++;
          if (core_en) begin
            pend = 1'b1;
            cnt  = core_lat;
            res  = speck(core_text, core_key, core_decrypt);
          end
        end
      end
    end
  end

  // Response scoreboard: compare at every accepted response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && ((rsp_valid & rsp_ready) != 2'b00)) begin
        if (sb.size() == 0) begin
          check_eq("sb_unexpected_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("rsp_idx", rsp_valid, 2'b01 << e.idx);
          check_eq("rsp_data", rsp_data, e.data);
          check_eq("rsp_error", rsp_error, e.err);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (req_ready != 2'b00) check_eq("req_ready_onehot", $onehot(req_ready), 1);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the accepting cycle.
  task automatic submit(input int idx, input logic dec, input logic [127:0] txt,
                        input logic [127:0] key, output int lat_rdy);
    req_decrypt[idx]         = dec;
    req_text[idx*128 +: 128] = txt;
    req_key[idx*128 +: 128]  = key;
    req_valid[idx]           = 1'b1;
    lat_rdy = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        lat_rdy = i;
        break;
      end
    end
    if (lat_rdy < 0) check_eq("submit_timeout", 0, 1);
    @(negedge clk);
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) return;
    end
    check_eq("drain_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},      busy, 0);
    check_eq({tag, "_req_ready"}, req_ready, 0);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    check_eq({tag, "_core_start"}, core_start, 0);
    check_eq({tag, "_core_blk"},  {core_decrypt, core_text, core_key} == '0, 1);
    check_eq({tag, "_rsp"},       {rsp_error, rsp_data} == '0, 1);
  endtask

  initial begin
    int           lat, s0, seen, n, chg;
    logic [127:0] jt [4];
    logic [127:0] jk [4];
    logic         jd [4];
    logic [127:0] held;

    rst_n = 1'b0;
    req_valid = '0; req_decrypt = '0; req_text = '0; req_key = '0;
    rsp_ready = 2'b11;
    secret_storage_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single decrypt job with the published vector
    s0 = n_starts;
    push_exp(0, c_PT, 1'b0);
    submit(0, 1'b1, c_CT, c_KEY, lat);
    check_eq("req_ready_latency", lat, 1);
    check_eq("core_start_latency", core_start, 1);
    check_eq("core_decrypt_held", core_decrypt, 1);
    wait_drain();
    check_eq("single_start_count", n_starts - s0, 1);

    // Reset while waiting on the core
    core_en = 1'b0;
    submit(1, 1'b0, c_PT, c_KEY, lat);
    repeat (5) @(negedge clk);
    check_eq("midjob_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midjob_reset");
    @(negedge clk);
    rst_n = 1'b1;
    s0 = n_starts;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) seen++;
    end
    check_eq("post_reset_starts", n_starts - s0, 0);
    check_eq("post_reset_busy", seen, 0);
    core_en = 1'b1;

    // Contention: both requesters held valid for four jobs
    for (int j = 0; j < 4; j++) begin
      jt[j] = {$urandom, $urandom, $urandom, $urandom};
      jk[j] = {$urandom, $urandom, $urandom, $urandom};
      jd[j] = 1'($urandom_range(0, 1));
      push_exp(j % 2, speck(jt[j], jk[j], jd[j]), 1'b0);
    end
    for (int r = 0; r < 2; r++) begin
      req_decrypt[r]         = jd[r];
      req_text[r*128 +: 128] = jt[r];
      req_key[r*128 +: 128]  = jk[r];
    end
    req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      seen = 0;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        if (req_ready != 2'b00) begin
          seen = 1;
          break;
        end
      end
      check_eq("contention_grant_seen", seen, 1);
      check_eq("contention_grant_order", req_ready, 2'b01 << (j % 2));
      @(negedge clk);
      if (j < 2) begin
        req_decrypt[j % 2]         = jd[j+2];
        req_text[(j%2)*128 +: 128] = jt[j+2];
        req_key[(j%2)*128 +: 128]  = jk[j+2];
      end
    end
    req_valid = 2'b00;
    wait_drain();

    // Timeout: core never answers
    core_en = 1'b0;
    push_exp(0, '0, 1'b1);
    submit(0, 1'b0, c_PT, c_KEY, lat);
    check_eq("timeout_launch", core_start, 1);
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid != 2'b00) break;
    end
    check_eq("timeout_cycles", n, 1025);
    wait_drain();

    // core_ready on the final timeout cycle wins
    core_en  = 1'b1;
    core_lat = 1024;
    push_exp(1, speck(c_PT, c_KEY, 1'b0), 1'b0);
    submit(1, 1'b0, c_PT, c_KEY, lat);
    wait_drain();
    core_lat = 34;

    // Gating on secret_storage_ready; drop after grant must not abort
    secret_storage_ready = 1'b0;
    jt[0] = {$urandom, $urandom, $urandom, $urandom};
    push_exp(0, speck(jt[0], c_KEY, 1'b1), 1'b0);
    req_decrypt[0] = 1'b1;
    req_text[127:0] = jt[0];
    req_key[127:0] = c_KEY;
    req_valid[0] = 1'b1;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (req_ready != 2'b00 || busy) seen++;
    end
    check_eq("gate_no_grant", seen, 0);
    secret_storage_ready = 1'b1;
    @(negedge clk);
    check_eq("gate_grant_next", req_ready, 2'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    secret_storage_ready = 1'b0;
    wait_drain();
    secret_storage_ready = 1'b1;

    // Backpressure, foreign rsp_ready and a stray core_ready
    rsp_ready = 2'b01;
    jt[1] = {$urandom, $urandom, $urandom, $urandom};
    jt[2] = {$urandom, $urandom, $urandom, $urandom};
    push_exp(1, speck(jt[1], c_KEY, 1'b0), 1'b0);
    submit(1, 1'b0, jt[1], c_KEY, lat);
    push_exp(0, speck(jt[2], c_KEY, 1'b0), 1'b0);
    req_decrypt[0] = 1'b0;
    req_text[127:0] = jt[2];
    req_valid[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid[1]) begin
        seen = 1;
        break;
      end
    end
    check_eq("bp_rsp_seen", seen, 1);
    held = rsp_data;
    chg = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) stray_cnt++;
      if (rsp_data !== held || rsp_valid !== 2'b10) chg++;
      if (req_ready != 2'b00) seen++;
    end
    check_eq("bp_rsp_stable", chg, 0);
    check_eq("bp_no_grant", seen, 0);
    rsp_ready = 2'b11;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        seen = 1;
        break;
      end
    end
    check_eq("bp_next_grant", seen, 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_drain();
    check_eq("sb_empty_at_end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
